// File: rtl/iobus_timer_counter_if.sv
// IOBUS slave connection for the timer: MCU drives address/data/strobe,
// the timer returns combinational read data and an address-hit flag.
interface iobus_timer_counter_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_RD_DATA;
  logic        IOBUS_HIT;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  IOBUS_RD_DATA, IOBUS_HIT
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output IOBUS_RD_DATA, IOBUS_HIT
  );
endinterface

// File: rtl/iobus_timer_counter.sv
// Memory-mapped prescaled down-counter with one-shot/auto-reload and interrupt pulse.
// Define TMR_PWM_EN to add the COMPARE register at +0x10 and a registered PWM output.
module iobus_timer_counter #(
  parameter logic [31:0] BASE_AD    = 32'h11100000,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  iobus_timer_counter_if.slave  bus,
  output logic                  TMR_INTR,
  output logic                  PWM_OUT
);

  logic                  en, auto_rl, irq_en, pend;
  logic [31:0]           reload, count;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [31:0]           off;
  logic                  hit_csr, hit_rel, hit_cnt, hit_pre, hit_cmp;
  logic                  tick, expire;
`ifdef TMR_PWM_EN
  logic [31:0]           compare;
`endif

  // Offset from the base keeps the decode exact for any word-aligned BASE_AD.
  assign off     = bus.IOBUS_ADDR - BASE_AD;
  assign hit_csr = (off == 32'h0);
  assign hit_rel = (off == 32'h4);
  assign hit_cnt = (off == 32'h8);
  assign hit_pre = (off == 32'hC);
`ifdef TMR_PWM_EN
  assign hit_cmp = (off == 32'h10);
`else
  assign hit_cmp = 1'b0;
`endif

  assign bus.IOBUS_HIT = hit_csr | hit_rel | hit_cnt | hit_pre | hit_cmp;

  always_comb begin
    bus.IOBUS_RD_DATA = '0;
    if (hit_csr)      bus.IOBUS_RD_DATA = {28'd0, pend, irq_en, auto_rl, en};
    else if (hit_rel) bus.IOBUS_RD_DATA = reload;
    else if (hit_cnt) bus.IOBUS_RD_DATA = count;
    else if (hit_pre) bus.IOBUS_RD_DATA = 32'(prescale);
`ifdef TMR_PWM_EN
    else if (hit_cmp) bus.IOBUS_RD_DATA = compare;
`endif
  end

  assign tick   = en && (pcnt == prescale);
  assign expire = tick && (count == 32'd0);

  // Later assignments win: SW writes override tick/expire updates, except
  // PEND where a same-cycle expire overrides the W1C.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      irq_en   <= 1'b0;
      pend     <= 1'b0;
      reload   <= '0;
      count    <= '0;
      prescale <= '0;
      pcnt     <= '0;
      TMR_INTR <= 1'b0;
    end else begin
      if (!en || tick) pcnt <= '0;
      else             pcnt <= pcnt + 1'b1;

      if (tick) begin
        if (count != 32'd0) count <= count - 32'd1;
        else if (auto_rl)   count <= reload;
      end
      if (expire && !auto_rl) en <= 1'b0;

      TMR_INTR <= expire && irq_en;

      if (bus.IOBUS_WR && hit_csr) begin
        en      <= bus.IOBUS_OUT[0];
        auto_rl <= bus.IOBUS_OUT[1];
        irq_en  <= bus.IOBUS_OUT[2];
        if (bus.IOBUS_OUT[3]) pend <= 1'b0;
      end
      if (expire) pend <= 1'b1;

      if (bus.IOBUS_WR && hit_rel) begin
        reload <= bus.IOBUS_OUT;
        count  <= bus.IOBUS_OUT;
      end
      if (bus.IOBUS_WR && hit_pre) prescale <= bus.IOBUS_OUT[PRESCALE_W-1:0];
    end
  end

`ifdef TMR_PWM_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      compare <= '0;
      PWM_OUT <= 1'b0;
    end else begin
      if (bus.IOBUS_WR && hit_cmp) compare <= bus.IOBUS_OUT;
      PWM_OUT <= en && (count < compare);
    end
  end
`else
  assign PWM_OUT = 1'b0;
`endif

endmodule

// File: doc/iobus_timer_counter.md
Name: iobus_timer_counter

Overview:
- Memory-mapped down-counting timer on the OTTER IOBUS. Sits beside the switch/LED/SSEG MMIO decode: consumes MCU IOBUS writes, supplies read data to the wrapper's IOBUS_in mux, and produces the interrupt that drives the MCU intr input.
- Gives firmware periodic interrupts without a debounced button.
- Clocked by the divided MCU clock.

Parameters:
- BASE_AD, 32'h11100000, base address of the 4-register window; word-aligned.
- PRESCALE_W, 8, width of the prescale register and the prescale counter.

Ports:
- CLK  input  1  MCU clock (sclk domain).
- RST_N  input  1  reset, synchronous, active-low.
- IOBUS_ADDR  input  32  MCU IOBUS address.
- IOBUS_OUT  input  32  MCU write data.
- IOBUS_WR  input  1  MCU write strobe, one cycle per store.
- IOBUS_RD_DATA  output  32  read data for the addressed register; 0 when not hit.
- IOBUS_HIT  output  1  combinational; 1 when IOBUS_ADDR is BASE_AD+0x0, +0x4, +0x8 or +0xC.
- TMR_INTR  output  1  one-cycle interrupt pulse.
- PWM_OUT  output  1  PWM output; see Optional Feature.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-low on RST_N.
- Register map:
  - +0x0 CSR: bit0 EN, bit1 AUTO, bit2 IRQ_EN, bit3 PEND (write 1 to clear). Other bits read 0.
  - +0x4 RELOAD: 32 bits, R/W.
  - +0x8 COUNT: 32 bits, read-only; writes ignored.
  - +0xC PRESCALE: [PRESCALE_W-1:0], R/W; upper bits read 0.
- Reset (RST_N=0 at a CLK edge): CSR, RELOAD, COUNT, PRESCALE and the prescale counter all go to 0. TMR_INTR=0 and PWM_OUT=0. Reset takes effect mid-count, and any pending pulse is discarded.
- Reads are combinational, with no wait state, so they fit the wrapper's always_comb mux. A read of COUNT returns the current register value.
- Writes are registered when IOBUS_WR=1 and the address matches. They are visible on the next cycle.
- A RELOAD write also loads COUNT with the same value in that cycle.
- Prescale:
  - While EN=1, the prescale counter increments every cycle.
  - When prescale counter == PRESCALE, tick=1 and the counter wraps to 0. PRESCALE=0 therefore ticks every cycle.
  - While EN=0, the prescale counter is held at 0 and there are no ticks.
- Count, evaluated on a tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: expire. PEND <= 1. If AUTO=1, COUNT <= RELOAD. If AUTO=0, EN <= 0 and COUNT stays 0.
- Expiry period with AUTO=1 is (RELOAD+1)*(PRESCALE+1) cycles.
- TMR_INTR: registered; high for exactly one cycle, on the cycle after an expire, only if IRQ_EN=1 at the expire. PEND is a sticky status bit and does not re-pulse.
- Simultaneous events:
  - A software write to RELOAD beats a tick decrement of COUNT in the same cycle.
  - An expire setting PEND beats a same-cycle W1C, so PEND stays 1.
  - A CSR write clearing EN beats an expire clearing EN; no conflict, the result is EN=0.
  - A CSR write setting EN in the expire cycle with AUTO=0 leaves EN=1.
- Arithmetic is unsigned 32-bit. COUNT never underflows because a COUNT of 0 always reloads or stops.

Optional Feature:
- Macro TMR_PWM_EN.
- When defined:
  - Adds a COMPARE register at +0x10 (32 bits, R/W, reset 0). IOBUS_HIT also covers +0x10.
  - PWM_OUT is registered: 1 while EN=1 and COUNT < COMPARE, else 0.
- When undefined:
  - No COMPARE flops. PWM_OUT is tied to 0.
  - +0x10 does not hit: IOBUS_HIT=0 and IOBUS_RD_DATA=0.

Test Plan:
- Reset: hold RST_N=0 for 2 cycles, then read +0x0, +0x4, +0x8, +0xC -> all 0. IOBUS_HIT=1 for each; IOBUS_HIT=0 at 0x11000000.
- One-shot: RELOAD=3, PRESCALE=0, CSR=0x5 -> COUNT reads 3,2,1,0 on successive cycles, then expires. TMR_INTR pulses once, one cycle wide. PEND=1, EN=0, COUNT holds 0.
- Auto-reload with prescale: RELOAD=4, PRESCALE=2, CSR=0x7 -> TMR_INTR pulses every 15 cycles for at least 3 periods. COUNT steps every 3 cycles.
- W1C collision: write CSR=0x8 in the exact expire cycle -> PEND reads 1. Write 0x8 again later -> PEND reads 0 and no extra TMR_INTR.
- Reset mid-count: RELOAD=100, run 10 ticks, assert RST_N=0 for 1 cycle -> COUNT=0, EN=0, no TMR_INTR afterwards.
- With TMR_PWM_EN: RELOAD=9, COMPARE=3, PRESCALE=0, CSR=0x3 -> PWM_OUT is high 3 of every 10 cycles. Without the macro: PWM_OUT=0, and a read of +0x10 gives HIT=0 and data 0.
